// File: rtl/fp_acc_pkg.sv
// Shared definitions for the floating-point product accumulator.
// Build option: FP_ACC_ROUND_EN adds guard/round/sticky bits and
// round-to-nearest-even; without it, shifted-out bits are truncated.
package fp_acc_pkg;

  localparam int unsigned DEF_N    = 32;
  localparam int unsigned DEF_ES   = 8;
  localparam int unsigned DEF_CW   = 16;
  localparam int unsigned DEF_SS   = DEF_N - DEF_ES - 1;
  localparam int unsigned DEF_BIAS = 2**(DEF_ES-1) - 1;

  // Extra alignment bits below the mantissa LSB: guard, round, sticky.
`ifdef FP_ACC_ROUND_EN
  localparam int unsigned FP_XB = 3;
`else
  localparam int unsigned FP_XB = 0;
`endif

  // Canonical positive saturated word for the default format.
  localparam logic [DEF_N-1:0] FP_SAT_POS = {1'b0, {DEF_ES{1'b1}}, {DEF_SS{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp_product_accumulator_if.sv
// Operand-in / sum-out handshake bundle for fp_product_accumulator.
interface fp_product_accumulator_if
  import fp_acc_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned CW = DEF_CW
);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [CW-1:0] out_count;

  // Producer of operands and consumer of sums.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/fp_lzc.sv
// Parameterised leading-zero counter; all-zero input returns W.
module fp_lzc
  import fp_acc_pkg::*;
#(
  parameter  int unsigned W  = 25,
  localparam int unsigned CW = $clog2(W+1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count
);

  // Highest set bit wins since it is visited last.
  always_comb begin
    count = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (din[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_product_accumulator.sv
// Sequential sign-magnitude accumulator for packed {sign, exp, frac} products.
// Build option: FP_ACC_ROUND_EN enables guard/round/sticky alignment and
// round-to-nearest-even in NORM; otherwise alignment truncates.
module fp_product_accumulator
  import fp_acc_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned ES = DEF_ES,
  parameter int unsigned CW = DEF_CW
) (
  input logic                     clk,
  input logic                     rst_n,
  fp_product_accumulator_if.slave bus
);

  localparam int unsigned SS = N - ES - 1;
  localparam int unsigned XB = FP_XB;
  localparam int unsigned W  = SS + 1 + XB;     // aligned mantissa width
  localparam int unsigned LW = $clog2(W + 2);   // lzc width over W+1 bits
  localparam int unsigned EW = ES + 2;          // signed exponent headroom

  state_t        state;
  logic          in_ready_r, out_valid_r;
  logic [N-1:0]  out_data_r;
  logic [CW-1:0] count;

  logic          acc_sign, acc_sat;
  logic [ES-1:0] acc_exp;
  logic [SS:0]   acc_man;

  logic          op_sign, op_sat, op_last;
  logic [ES-1:0] op_exp;
  logic [SS:0]   op_man;

  logic [ES-1:0] al_exp;
  logic [W-1:0]  al_big, al_small;
  logic          al_big_sign, al_small_sign;

  logic [W:0]    sum_man;
  logic [ES-1:0] sum_exp;
  logic          sum_sign;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_count = count;

  logic [ES-1:0] in_exp;
  logic          in_zero, in_sat;
  assign in_exp  = bus.in_data[N-2 -: ES];
  assign in_zero = (in_exp == '0);
  assign in_sat  = (in_exp == '1);

  // Alignment: larger exponent wins, smaller mantissa shifted right.
  logic          acc_big;
  logic [ES-1:0] shift_d;
  logic [W-1:0]  big_c, small_c, shifted;
`ifdef FP_ACC_ROUND_EN
  logic          sticky;
`endif
  always_comb begin
    acc_big = (acc_exp >= op_exp);
    big_c   = acc_big ? (W'(acc_man) << XB) : (W'(op_man) << XB);
    small_c = acc_big ? (W'(op_man) << XB) : (W'(acc_man) << XB);
    shift_d = acc_big ? (acc_exp - op_exp) : (op_exp - acc_exp);
    shifted = small_c >> shift_d;
`ifdef FP_ACC_ROUND_EN
    sticky     = |(small_c & ~({W{1'b1}} << shift_d));
    shifted[0] = shifted[0] | sticky;
`endif
  end

  // Magnitude add/subtract; exact cancellation yields +0.
  logic [W:0] add_r;
  logic       add_sign;
  always_comb begin
    add_r    = '0;
    add_sign = al_big_sign;
    if (al_big_sign == al_small_sign) begin
      add_r = {1'b0, al_big} + {1'b0, al_small};
    end else if (al_big >= al_small) begin
      add_r = {1'b0, al_big} - {1'b0, al_small};
    end else begin
      add_r    = {1'b0, al_small} - {1'b0, al_big};
      add_sign = al_small_sign;
    end
    if (add_r == '0) add_sign = 1'b0;
  end

  logic [LW-1:0] lz;
  fp_lzc #(.W(W + 1)) u_lzc (
    .din   (sum_man),
    .count (lz)
  );

  // Normalise, optionally round, then apply zero/underflow/saturation rules.
  logic [W-1:0]          norm_m;
  logic signed [EW-1:0]  norm_e;
  logic [SS:0]           norm_man;
  logic                  n_sign, n_sat;
  logic [ES-1:0]         n_exp;
  logic [SS:0]           n_man;
  logic [N-1:0]          n_word;
`ifdef FP_ACC_ROUND_EN
  logic                  round_up;
  logic [SS+1:0]         man_r;
`endif
  always_comb begin
    if (sum_man[W]) begin
      norm_m = sum_man[W:1];
`ifdef FP_ACC_ROUND_EN
      norm_m[0] = norm_m[0] | sum_man[0];
`endif
      norm_e = $signed(EW'(sum_exp)) + $signed(EW'(1));
    end else begin
      norm_m = sum_man[W-1:0] << (lz - LW'(1));
      norm_e = $signed(EW'(sum_exp)) - $signed(EW'(lz)) + $signed(EW'(1));
    end
`ifdef FP_ACC_ROUND_EN
    round_up = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
    man_r    = {1'b0, norm_m[W-1:3]} + (SS+2)'(round_up);
    if (man_r[SS+1]) begin
      norm_man = man_r[SS+1:1];
      norm_e   = norm_e + $signed(EW'(1));
    end else begin
      norm_man = man_r[SS:0];
    end
`else
    norm_man = norm_m;
`endif
    n_sign = acc_sign;
    n_sat  = acc_sat;
    n_exp  = acc_exp;
    n_man  = acc_man;
    if (acc_sat) begin
      n_sat = 1'b1;
    end else if (op_sat) begin
      n_sat  = 1'b1;
      n_sign = op_sign;
    end else if ((sum_man == '0) || (norm_e < $signed(EW'(1)))) begin
      n_sign = 1'b0;
      n_exp  = '0;
      n_man  = '0;
    end else if (norm_e >= $signed(EW'({ES{1'b1}}))) begin
      n_sat  = 1'b1;
      n_sign = sum_sign;
    end else begin
      n_sign = sum_sign;
      n_exp  = norm_e[ES-1:0];
      n_man  = norm_man;
    end
    n_word = n_sat ? {n_sign, {ES{1'b1}}, {SS{1'b0}}}
                   : {n_sign, n_exp, n_man[SS-1:0]};
  end

  // Control FSM with registered handshake outputs and pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      count         <= '0;
      acc_sign      <= 1'b0;
      acc_sat       <= 1'b0;
      acc_exp       <= '0;
      acc_man       <= '0;
      op_sign       <= 1'b0;
      op_sat        <= 1'b0;
      op_last       <= 1'b0;
      op_exp        <= '0;
      op_man        <= '0;
      al_exp        <= '0;
      al_big        <= '0;
      al_small      <= '0;
      al_big_sign   <= 1'b0;
      al_small_sign <= 1'b0;
      sum_man       <= '0;
      sum_exp       <= '0;
      sum_sign      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            op_sign    <= bus.in_data[N-1];
            op_sat     <= in_sat;
            op_last    <= bus.in_last;
            op_exp     <= in_zero ? '0 : in_exp;
            op_man     <= in_zero ? '0 : {1'b1, bus.in_data[SS-1:0]};
            count      <= (count == '1) ? count : count + CW'(1);
            in_ready_r <= 1'b0;
            state      <= ALIGN;
          end
        end
        ALIGN: begin
          al_exp        <= acc_big ? acc_exp : op_exp;
          al_big        <= big_c;
          al_small      <= shifted;
          al_big_sign   <= acc_big ? acc_sign : op_sign;
          al_small_sign <= acc_big ? op_sign : acc_sign;
          state         <= ADD;
        end
        ADD: begin
          sum_man  <= add_r;
          sum_exp  <= al_exp;
          sum_sign <= add_sign;
          state    <= NORM;
        end
        NORM: begin
          acc_sign <= n_sign;
          acc_sat  <= n_sat;
          acc_exp  <= n_exp;
          acc_man  <= n_man;
          if (op_last) begin
            out_data_r  <= n_word;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            in_ready_r <= 1'b1;
            state      <= IDLE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            acc_sign    <= 1'b0;
            acc_sat     <= 1'b0;
            acc_exp     <= '0;
            acc_man     <= '0;
            count       <= '0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_product_accumulator.sv
// Directed self-checking bench for fp_product_accumulator.
module tb_fp_product_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  fp_product_accumulator_if #(.N(32), .CW(16)) bus ();

  fp_product_accumulator #(.N(32), .ES(8), .CW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Present an operand (called at a negedge) until accepted; returns at the
  // negedge after the accepting edge with in_valid still high.
  task automatic send(input logic [31:0] d, input logic last,
                      output logic ok, output int acc_edge);
    ok = 1'b0;
    acc_edge = -1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int i = 0; i < 30; i++) begin
      if (bus.in_ready) begin
        acc_edge = cyc + 1;
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  // Wait (bounded) for out_valid; rise is the edge that raised it.
  task automatic wait_out(output logic ok, output int rise);
    ok = 1'b0;
    rise = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        rise = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take_out;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    n_checks++;
    if (bus.out_count !== 16'h0) begin n_fail++; $display("FAIL reset_out_count got=%0d exp=0", bus.out_count); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready); end
  endtask

  // 1.0 + 2.0 + 0.5 = 3.5, operands back to back.
  task automatic test_sum3;
    logic ok, all_ok;
    int e0, e, rise;
    all_ok = 1'b1;
    send(32'h3F800000, 1'b0, ok, e0); all_ok &= ok;
    send(32'h40000000, 1'b0, ok, e);  all_ok &= ok;
    send(32'h3F000000, 1'b1, ok, e);  all_ok &= ok;
    bus.in_valid = 1'b0;
    wait_out(ok, rise); all_ok &= ok;
    n_checks++;
    if (!all_ok) begin n_fail++; $display("FAIL sum3_handshake got=timeout exp=complete"); end
    n_checks++;
    if (bus.out_data !== 32'h40600000) begin n_fail++; $display("FAIL sum3_data got=%h exp=40600000", bus.out_data); end
    n_checks++;
    if (bus.out_count !== 16'd3) begin n_fail++; $display("FAIL sum3_count got=%0d exp=3", bus.out_count); end
    // Accepts at E0/E4/E8, valid 3 edges later: E11, i.e. seen in the
    // 12th cycle counting the first accept cycle.
    n_checks++;
    if (rise - e0 !== 11) begin n_fail++; $display("FAIL sum3_latency got=%0d exp=11", rise - e0); end
    take_out();
  endtask

  task automatic test_cancel;
    logic ok, all_ok;
    int e, rise;
    all_ok = 1'b1;
    send(32'h3F800000, 1'b0, ok, e); all_ok &= ok;
    send(32'hBF800000, 1'b1, ok, e); all_ok &= ok;
    bus.in_valid = 1'b0;
    wait_out(ok, rise); all_ok &= ok;
    n_checks++;
    if (bus.out_data !== 32'h00000000) begin n_fail++; $display("FAIL cancel_data got=%h exp=00000000", bus.out_data); end
    n_checks++;
    if (bus.out_count !== 16'd2) begin n_fail++; $display("FAIL cancel_count got=%0d exp=2", bus.out_count); end
    take_out();
    // 1.0 + -2.0 = -1.0: larger magnitude sets the sign.
    send(32'h3F800000, 1'b0, ok, e); all_ok &= ok;
    send(32'hC0000000, 1'b1, ok, e); all_ok &= ok;
    bus.in_valid = 1'b0;
    wait_out(ok, rise); all_ok &= ok;
    n_checks++;
    if (bus.out_data !== 32'hBF800000) begin n_fail++; $display("FAIL negsum_data got=%h exp=BF800000", bus.out_data); end
    n_checks++;
    if (!all_ok) begin n_fail++; $display("FAIL cancel_handshake got=timeout exp=complete"); end
    take_out();
  endtask

  task automatic test_saturate;
    logic ok, all_ok;
    int e, rise;
    all_ok = 1'b1;
    send(32'h3F800000, 1'b0, ok, e); all_ok &= ok;
    send(32'h7F800000, 1'b0, ok, e); all_ok &= ok;
    send(32'h3F800000, 1'b1, ok, e); all_ok &= ok;
    bus.in_valid = 1'b0;
    wait_out(ok, rise); all_ok &= ok;
    n_checks++;
    if (bus.out_data !== 32'h7F800000) begin n_fail++; $display("FAIL sat_in_data got=%h exp=7F800000", bus.out_data); end
    n_checks++;
    if (bus.out_count !== 16'd3) begin n_fail++; $display("FAIL sat_in_count got=%0d exp=3", bus.out_count); end
    take_out();
    // 2^127 + 2^127 overflows the exponent into saturation.
    send(32'h7F000000, 1'b0, ok, e); all_ok &= ok;
    send(32'h7F000000, 1'b1, ok, e); all_ok &= ok;
    bus.in_valid = 1'b0;
    wait_out(ok, rise); all_ok &= ok;
    n_checks++;
    if (bus.out_data !== 32'h7F800000) begin n_fail++; $display("FAIL sat_ovf_data got=%h exp=7F800000", bus.out_data); end
    n_checks++;
    if (!all_ok) begin n_fail++; $display("FAIL sat_handshake got=timeout exp=complete"); end
    take_out();
  endtask

  // 1.0 + 1.5*2^-24 = 1 + 0.75 ulp.
  task automatic test_round;
    logic ok, all_ok;
    int e, rise;
    logic [31:0] exp_word;
`ifdef FP_ACC_ROUND_EN
    exp_word = 32'h3F800001;
`else
    exp_word = 32'h3F800000;
`endif
    all_ok = 1'b1;
    send(32'h3F800000, 1'b0, ok, e); all_ok &= ok;
    send(32'h33C00000, 1'b1, ok, e); all_ok &= ok;
    bus.in_valid = 1'b0;
    wait_out(ok, rise); all_ok &= ok;
    n_checks++;
    if (bus.out_data !== exp_word) begin n_fail++; $display("FAIL round_data got=%h exp=%h", bus.out_data, exp_word); end
    n_checks++;
    if (!all_ok) begin n_fail++; $display("FAIL round_handshake got=timeout exp=complete"); end
    take_out();
  endtask

  task automatic test_backpressure;
    logic ok, all_ok;
    int e, rise;
    all_ok = 1'b1;
    send(32'h40000000, 1'b1, ok, e); all_ok &= ok;
    bus.in_valid = 1'b0;
    wait_out(ok, rise); all_ok &= ok;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F800000;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_data !== 32'h40000000) begin n_fail++; $display("FAIL hold_data[%0d] got=%h exp=40000000", i, bus.out_data); end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
      n_checks++;
      if (bus.out_count !== 16'd1) begin n_fail++; $display("FAIL hold_count[%0d] got=%0d exp=1", i, bus.out_count); end
    end
    take_out();
    send(32'h3F800000, 1'b1, ok, e); all_ok &= ok;
    bus.in_valid = 1'b0;
    wait_out(ok, rise); all_ok &= ok;
    n_checks++;
    if (bus.out_data !== 32'h3F800000) begin n_fail++; $display("FAIL fresh_data got=%h exp=3F800000", bus.out_data); end
    n_checks++;
    if (bus.out_count !== 16'd1) begin n_fail++; $display("FAIL fresh_count got=%0d exp=1", bus.out_count); end
    n_checks++;
    if (!all_ok) begin n_fail++; $display("FAIL hold_handshake got=timeout exp=complete"); end
    take_out();
  endtask

  task automatic test_reset_mid;
    logic ok, all_ok;
    int e, rise;
    all_ok = 1'b1;
    send(32'h3F800000, 1'b0, ok, e); all_ok &= ok;
    send(32'h40000000, 1'b1, ok, e); all_ok &= ok;
    bus.in_valid = 1'b0;
    @(negedge clk);            // now in ADD of the second term
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL midrst_out_data got=%h exp=0", bus.out_data); end
    n_checks++;
    if (bus.out_count !== 16'h0) begin n_fail++; $display("FAIL midrst_out_count got=%0d exp=0", bus.out_count); end
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h40400000, 1'b1, ok, e); all_ok &= ok;
    bus.in_valid = 1'b0;
    wait_out(ok, rise); all_ok &= ok;
    n_checks++;
    if (bus.out_data !== 32'h40400000) begin n_fail++; $display("FAIL postrst_data got=%h exp=40400000", bus.out_data); end
    n_checks++;
    if (bus.out_count !== 16'd1) begin n_fail++; $display("FAIL postrst_count got=%0d exp=1", bus.out_count); end
    n_checks++;
    if (!all_ok) begin n_fail++; $display("FAIL midrst_handshake got=timeout exp=complete"); end
    take_out();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_sum3();
    test_cancel();
    test_saturate();
    test_round();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
